// File: rtl/byte_producer.sv
// ============================================================================
//  Module      : byte_producer
//  Description : Buffers handshaked multi-byte words in a small FIFO and
//                serializes each one LSB-first onto a byte stream.
//                Optional macro BYTE_PRODUCER_CNT_EN adds a saturating
//                output byte counter port (byte_count).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_producer #(
    parameter int IN_W       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_W-1:0]                 in_data,
    input  logic [$clog2(IN_W/8):0]         in_len,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [7:0]                      data_out,
    output logic                            data_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
`ifdef BYTE_PRODUCER_CNT_EN
    output logic                            busy,
    output logic [15:0]                     byte_count
`else
    output logic                            busy
`endif
);

    localparam int c_nb  = IN_W / 8;
    localparam int c_lw  = $clog2(c_nb) + 1;
    localparam int c_pw  = $clog2(FIFO_DEPTH);
    localparam int c_lvw = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_lw-1:0]  c_len_nb  = c_lw'(c_nb);
    localparam logic [c_lw-1:0]  c_len_one = c_lw'(1);
    localparam logic [c_pw-1:0]  c_ptr_one = c_pw'(1);
    localparam logic [c_lvw-1:0] c_lvl_one = c_lvw'(1);
    localparam logic [c_lvw-1:0] c_lvl_max = c_lvw'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [IN_W-1:0]  r_mem_data [FIFO_DEPTH];
    logic [c_lw-1:0]  r_mem_len  [FIFO_DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_lvw-1:0] r_level;

    logic [0:0]       r_state;
    logic [IN_W-1:0]  r_hold;
    logic [c_lw-1:0]  r_remaining;
    logic [7:0]       r_data_out;
    logic             r_data_valid;

    logic [0:0]       w_state_nxt;
    logic [IN_W-1:0]  w_hold_nxt;
    logic [c_lw-1:0]  w_rem_nxt;
    logic [7:0]       w_dout_nxt;
    logic             w_dvalid_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic [c_lw-1:0]  w_len_norm;

    // Full blocks acceptance even when a pop lands on the same edge.
    assign w_full     = (r_level == c_lvl_max);
    assign in_ready   = !rst && !w_full;
    assign w_push     = in_valid && in_ready;
    assign w_len_norm = ((in_len == '0) || (in_len > c_len_nb)) ? c_len_nb : in_len;

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign fifo_level = r_level;
    assign busy       = r_data_valid || (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_len[r_wr_ptr]  <= w_len_norm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_remaining  <= '0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_remaining  <= w_rem_nxt;
            r_data_out   <= w_dout_nxt;
            r_data_valid <= w_dvalid_nxt;
        end
    end

    // An in-flight word always wins over a pop, so the stream never gaps.
    always_comb begin
        w_pop        = 1'b0;
        w_hold_nxt   = r_hold;
        w_rem_nxt    = r_remaining;
        w_dout_nxt   = r_data_out;
        w_dvalid_nxt = 1'b0;
        if (r_state == S_SHIFT) begin
            w_dout_nxt   = r_hold[7:0];
            w_hold_nxt   = r_hold >> 8;
            w_rem_nxt    = r_remaining - c_len_one;
            w_dvalid_nxt = 1'b1;
        end else if (r_level != '0) begin
            w_pop        = 1'b1;
            w_dout_nxt   = r_mem_data[r_rd_ptr][7:0];
            w_hold_nxt   = r_mem_data[r_rd_ptr] >> 8;
            w_rem_nxt    = r_mem_len[r_rd_ptr] - c_len_one;
            w_dvalid_nxt = 1'b1;
        end
        w_state_nxt = (w_rem_nxt != '0) ? S_SHIFT : S_IDLE;
    end

`ifdef BYTE_PRODUCER_CNT_EN
    logic [15:0] r_byte_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_count <= 16'h0000;
        end else if (w_dvalid_nxt && (r_byte_count != 16'hFFFF)) begin
            r_byte_count <= r_byte_count + 16'h0001;
        end
    end

    assign byte_count = r_byte_count;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_byte_producer.sv
// ============================================================================
//  Module      : tb_byte_producer
//  Description : Directed scoreboard bench for byte_producer (IN_W=32,
//                FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_producer;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [2:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [2:0]  fifo_level;
    logic        busy;
`ifdef BYTE_PRODUCER_CNT_EN
    logic [15:0] byte_count;
`endif

    int        n_cmp  = 0;
    int        n_fail = 0;
    logic [7:0] q[$];
    int        run      = 0;
    int        last_run = 0;
    int        stalls   = 0;

    byte_producer #(.IN_W(32), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_level (fifo_level),
`ifdef BYTE_PRODUCER_CNT_EN
        .busy       (busy),
        .byte_count (byte_count)
`else
        .busy       (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every valid byte must match the head of the scoreboard.
    always @(negedge clk) begin
        logic       have;
        logic [7:0] exp;
        if (data_valid === 1'b1) begin
            run++;
            have = (q.size() != 0);
            n_cmp++;
            assert (have) else begin
                n_fail++;
                $error("FAIL extra_byte: observed %02h, expected no valid byte", data_out);
            end
            if (have) begin
                exp = q.pop_front();
                n_cmp++;
                assert (data_out === exp) else begin
                    n_fail++;
                    $error("FAIL stream_byte: observed %02h, expected %02h", data_out, exp);
                end
            end
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic [2:0] len);
        int nlen;
        int k;
        in_data  = d;
        in_len   = len;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            if (k == 0) begin
                stalls++;
                chk("full_level_when_not_ready", 32'(fifo_level), 32'd4);
            end
            step();
            k++;
        end
        if (k >= 50) begin
            chk("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            nlen = (len == 3'd0 || len > 3'd4) ? 4 : int'(len);
            for (int i = 0; i < nlen; i++) q.push_back(d[8*i +: 8]);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy !== 1'b0 || q.size() != 0) && k < 300) begin
            step();
            k++;
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_len   = '0;
        in_valid = 1'b0;
        #1;
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Single word with first-byte latency
        push_word(32'h44332211, 3'd4);
        step();
        chk("latency_no_valid_yet", 32'(data_valid), 32'd0);
        chk("level_after_accept", 32'(fifo_level), 32'd1);
        chk("busy_after_accept", 32'(busy), 32'd1);
        step();
        chk("first_byte_valid", 32'(data_valid), 32'd1);
        chk("first_byte_value", 32'(data_out), 32'h11);
        wait_idle();
        chk("single_run_len", 32'(last_run), 32'd4);

        // Short word and length normalization
        push_word(32'hDDCCBBAA, 3'd2);
        wait_idle();
        chk("short_run_len", 32'(last_run), 32'd2);
        push_word(32'h44332211, 3'd0);
        wait_idle();
        chk("len0_run_len", 32'(last_run), 32'd4);
        push_word(32'h88776655, 3'd7);
        wait_idle();
        chk("len7_run_len", 32'(last_run), 32'd4);

        // Fill and backpressure: six back-to-back full-length words
        stalls   = 0;
        last_run = 0;
        for (int w = 0; w < 6; w++) begin
            push_word({8'(w * 4 + 4), 8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1)}, 3'd4);
        end
        wait_idle();
        chk("fill_saw_backpressure", 32'(stalls > 0), 32'd1);
        chk("fill_gapless_run", 32'(last_run), 32'd24);

        // Reset in the middle of a word
        begin
            int k;
            push_word(32'h44332211, 3'd4);
            k = 0;
            while (!(data_valid === 1'b1 && data_out === 8'h22) && k < 20) begin
                step();
                k++;
            end
            chk("saw_byte_22", 32'(k < 20), 32'd1);
            rst = 1'b1;
            #1;
            chk("ready_low_in_reset", 32'(in_ready), 32'd0);
            q.delete();
            step();
            chk("midrst_data_valid", 32'(data_valid), 32'd0);
            chk("midrst_data_out", 32'(data_out), 32'h00);
            chk("midrst_fifo_level", 32'(fifo_level), 32'd0);
            rst = 1'b0;
            step();
            step();
            push_word(32'h000000EE, 3'd1);
            wait_idle();
            chk("single_byte_run", 32'(last_run), 32'd1);
        end

`ifdef BYTE_PRODUCER_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_word(32'hA3A2A1A0, 3'd4);
        push_word(32'hB3B2B1B0, 3'd1);
        push_word(32'hC3C2C1C0, 3'd2);
        wait_idle();
        chk("byte_count_7", 32'(byte_count), 32'd7);
        rst = 1'b1;
        step();
        chk("byte_count_rst", 32'(byte_count), 32'd0);
        rst = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
